// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter
// Turns the pull interface of a synchronous FIFO (one-cycle read latency) into
// a valid/ready stream. Reads are issued on credit: a read is only requested
// when the output buffer has room for every word already in flight. The
// downstream ready therefore never reaches fifo_rd_en combinationally. The block
// also keeps a wrapping count of the words it has delivered.
module fifo_rd_stream_adapter #(
  parameter int FIFO_WIDTH = 16,
  parameter int BUF_DEPTH  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [FIFO_WIDTH-1:0]            fifo_dout,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  output logic [FIFO_WIDTH-1:0]            m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_count,
  output logic [CNT_WIDTH-1:0]             words_out
);

  // Occupancy needs to represent 0..BUF_DEPTH; pointers address 0..BUF_DEPTH-1.
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  localparam logic [PW-1:0] PTR_LAST = PW'(BUF_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(BUF_DEPTH);

  // Buffer storage and bookkeeping state.
  logic [FIFO_WIDTH-1:0] buf_mem_reg [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         wr_ptr_next;
  logic [PW-1:0]         rd_ptr_reg;
  logic [PW-1:0]         rd_ptr_next;
  logic [CW-1:0]         count_reg;
  logic [CW-1:0]         count_next;
  logic                  inflight_reg;
  logic [CNT_WIDTH-1:0]  words_reg;
  logic [CNT_WIDTH-1:0]  words_next;

  // Event strobes for the current cycle.
  logic                  capture;
  logic                  pop;
  logic [CW:0]           credit_sum;
  logic                  rd_en_int;

  // A word requested at the previous edge is on fifo_dout now and must be taken.
  assign capture = inflight_reg;

  // Output is valid purely from registered occupancy, so it holds under backpressure.
  assign m_valid = (count_reg != '0);
  assign pop     = m_valid & m_ready;

  // Words buffered plus the word still on its way from the FIFO.
  assign credit_sum = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};

  // Read only when every outstanding word is guaranteed a slot; a pop in the
  // same cycle is deliberately not credited so m_ready stays off this path.
  assign rd_en_int  = !rst && !fifo_empty && (credit_sum < DEPTH_C);
  assign fifo_rd_en = rd_en_int;

  assign m_data    = buf_mem_reg[rd_ptr_reg];
  assign buf_count = count_reg;
  assign words_out = words_reg;

  // Next write pointer: advance on capture, wrapping at the last entry.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    if (capture) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PW'(1);
    end
  end

  // Next read pointer: advance on a completed handshake, wrapping at the last entry.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PW'(1);
    end
  end

  // Next occupancy: capture and pop in the same cycle cancel out.
  always_comb begin
    count_next = count_reg;
    unique case ({capture, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Next delivered-word count; wraps naturally at 2^CNT_WIDTH.
  always_comb begin
    words_next = words_reg;
    if (pop) begin
      words_next = words_reg + CNT_WIDTH'(1);
    end
  end

  // Pointer, occupancy, in-flight and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= 1'b0;
      words_reg    <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      inflight_reg <= rd_en_int;
      words_reg    <= words_next;
    end
  end

  // One register per buffer entry; cleared on reset so m_data reads 0 afterwards.
  generate
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      logic entry_we;
      assign entry_we = capture && (wr_ptr_reg == PW'(gi));

      // Load the entry when the in-flight word lands at this slot.
      always_ff @(posedge clk) begin
        if (rst) begin
          buf_mem_reg[gi] <= '0;
        end else if (entry_we) begin
          buf_mem_reg[gi] <= fifo_dout;
        end
      end
    end
  endgenerate

  // The credit rule must keep buffered plus in-flight words within capacity.
  a_credit_bound : assert property (@(posedge clk) disable iff (rst)
    credit_sum <= DEPTH_C);

  // A capture into a full buffer would overwrite the head; it must never happen.
  a_no_full_capture : assert property (@(posedge clk) disable iff (rst)
    capture |-> (count_reg < CW'(BUF_DEPTH)));

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter
// Drives the adapter from a queue-based model of the upstream synchronous FIFO
// and checks the output stream against an end-to-end scoreboard: every word
// pushed into the FIFO must appear at the stream output, in order, exactly once.
module tb_fifo_rd_stream_adapter;

  localparam int W    = 16;
  localparam int D    = 3;
  localparam int CNTW = 16;
  localparam int BCW  = $clog2(D + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [W-1:0]    fifo_dout = '0;
  logic            fifo_empty = 1'b1;
  logic            fifo_rd_en;
  logic [W-1:0]    m_data;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [BCW-1:0]  buf_count;
  logic [CNTW-1:0] words_out;

  logic            push_en = 1'b0;
  logic [W-1:0]    push_data = '0;

  int              vec_cnt = 0;
  int              err_cnt = 0;

  logic [W-1:0]    fq[$];     // upstream FIFO contents
  logic [W-1:0]    exp_q[$];  // words still owed at the stream output
  int              exp_words = 0;
  logic            prev_hold = 1'b0;
  logic [W-1:0]    prev_data = '0;
  int              rd_pulses = 0;

  fifo_rd_stream_adapter #(
    .FIFO_WIDTH(W),
    .BUF_DEPTH (D),
    .CNT_WIDTH (CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .buf_count (buf_count),
    .words_out (words_out)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: one-cycle read latency, write visible after the edge.
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
    end else begin
      if (fifo_rd_en) fifo_dout <= fq.pop_front();
      if (push_en) fq.push_back(push_data);
    end
    fifo_empty <= (fq.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs at the falling edge, then check the settled outputs
  // and account for the handshake that the next rising edge will complete.
  task automatic cycle(input logic r, input logic rdy, input logic pe, input logic [W-1:0] pd);
    @(negedge clk);
    rst       = r;
    m_ready   = rdy & ~r;
    push_en   = pe & ~r;
    push_data = pd;
    #1;
    if (fifo_rd_en) rd_pulses++;
    if (r) begin
      chk("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
      exp_q.delete();
      exp_words = 0;
      prev_hold = 1'b0;
    end else begin
      chk("count_bound", 32'(buf_count <= BCW'(D)), 32'd1);
      chk("words_out", 32'(words_out), 32'(CNTW'(exp_words)));
      if (prev_hold) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'(m_valid), 32'd0);
        end else begin
          chk("data", 32'(m_data), 32'(exp_q.pop_front()));
          exp_words++;
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      if (pe) exp_q.push_back(pd);
    end
  endtask

  // Deliver everything owed with ready held high, within a cycle budget.
  task automatic drain(input int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) cycle(1'b0, 1'b1, 1'b0, '0);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    int bubbles;
    bit started;

    // Reset and idle with an empty FIFO.
    cycle(1'b1, 1'b0, 1'b0, '0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_count", 32'(buf_count), 32'd0);
    chk("rst_words", 32'(words_out), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      chk("idle_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("idle_valid", 32'(m_valid), 32'd0);
      chk("idle_count", 32'(buf_count), 32'd0);
    end

    // First-word latency: empty falls, read in cycle 0, valid in cycle 2.
    cycle(1'b0, 1'b1, 1'b1, 16'hA5A5);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("lat_c0_rd_en", 32'(fifo_rd_en), 32'd1);
    chk("lat_c0_valid", 32'(m_valid), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("lat_c1_valid", 32'(m_valid), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("lat_c2_valid", 32'(m_valid), 32'd1);
    chk("lat_c2_data", 32'(m_data), 32'h0000A5A5);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("lat_words", 32'(words_out), 32'd1);

    // Streaming: ten words, no bubbles once the first one appears.
    bubbles = 0;
    started = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 1'b1, 1'b1, W'(i));
      if (m_valid) started = 1'b1;
      else if (started && exp_q.size() != 0) bubbles++;
    end
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
      cycle(1'b0, 1'b1, 1'b0, '0);
      if (m_valid) started = 1'b1;
      else if (started && exp_q.size() != 0) bubbles++;
    end
    chk("stream_left", 32'(exp_q.size()), 32'd0);
    chk("stream_bubbles", 32'(bubbles), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("stream_words", 32'(words_out), 32'd11);

    // Backpressure: eight words queued, ready low; only three reads may issue.
    rd_pulses = 0;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, W'(16'h0100 + i));
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, '0);
    chk("bp_rd_pulses", 32'(rd_pulses), 32'd3);
    chk("bp_count", 32'(buf_count), 32'd3);
    chk("bp_head", 32'(m_data), 32'h00000100);
    drain(30);
    chk("bp_words", 32'(words_out), 32'd19);

    // Random ready and random FIFO writes against the scoreboard.
    for (int n = 0; n < 200; n++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 4), W'($urandom));
    end
    drain(100);
    chk("rand_words", 32'(words_out), 32'(CNTW'(exp_words)));

    // Reset mid-stream with two words buffered and one in flight.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, W'(16'h0200 + i));
    cycle(1'b0, 1'b0, 1'b0, '0);
    chk("mid_rd_en_before", 32'(fifo_rd_en), 32'd1);
    @(posedge clk);
    #1;
    chk("mid_count", 32'(buf_count), 32'd2);
    chk("mid_rd_en", 32'(fifo_rd_en), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("post_rst_count", 32'(buf_count), 32'd0);
    chk("post_rst_valid", 32'(m_valid), 32'd0);
    chk("post_rst_words", 32'(words_out), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, W'(16'h0300 + i));
    drain(20);
    chk("post_rst_total", 32'(words_out), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_rd_stream_adapter.md
Name: fifo_rd_stream_adapter

Overview:
Read-side consumer placed directly downstream of the synchronous FIFO. It converts the FIFO's pull interface (rd_en, data_out, empty, with one-cycle read latency) into a valid/ready stream for the next stage. A small internal output buffer absorbs the read latency, so the block sustains one word per clock without a combinational path from m_ready to fifo_rd_en. It also counts the words it delivers.

Parameters:
FIFO_WIDTH, 16, data word width; must match the upstream FIFO.
BUF_DEPTH, 3, output buffer entries; minimum 3 for full throughput.
CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous reset, active-high.
fifo_dout  input  FIFO_WIDTH  upstream FIFO data_out; valid the cycle after a rd_en edge.
fifo_empty  input  1  upstream FIFO empty flag.
fifo_rd_en  output  1  read request to the upstream FIFO.
m_data  output  FIFO_WIDTH  stream data (head of the buffer).
m_valid  output  1  stream valid.
m_ready  input  1  stream ready from downstream.
buf_count  output  $clog2(BUF_DEPTH+1)  current buffer occupancy.
words_out  output  CNT_WIDTH  number of completed handshakes; wraps.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge) clears:
  - buffer pointers, and buf_count to 0;
  - the inflight flag;
  - words_out to 0;
  - m_valid to 0, and m_data to 0.
- While rst=1, fifo_rd_en is forced to 0.
- Interface: single clock; reset is synchronous and active-high.
- fifo_rd_en is combinational: fifo_rd_en = !rst & !fifo_empty & (buf_count + inflight < BUF_DEPTH).
  - It does not depend on m_ready. A same-cycle pop is never credited.
- inflight register: inflight <= fifo_rd_en at every edge.
- Capture: at an edge with inflight=1, fifo_dout is written at the write pointer. This is the edge following the rd_en edge.
- Pop: at an edge with m_valid & m_ready, the head entry is removed and words_out increments.
  - words_out wraps from 2^CNT_WIDTH-1 to 0.
- Simultaneous capture and pop: buf_count is unchanged and both pointers advance.
- Pointers wrap modulo BUF_DEPTH.
- m_valid = (buf_count != 0), registered-state derived. m_data = buffer[rd_ptr].
- m_data and m_valid stay stable while m_valid=1 & m_ready=0 (AXI-style hold).
- Latency: fifo_empty falls at cycle 0 with the buffer empty.
  - fifo_rd_en=1 in cycle 0.
  - Capture happens at the edge ending cycle 1.
  - m_valid=1 in cycle 2.
- Throughput: with m_ready held at 1 and the FIFO non-empty, the steady state is buf_count=1, inflight=1, fifo_rd_en=1 every cycle, one word per cycle.
- Backpressure: with m_ready=0, reads continue until buf_count+inflight=BUF_DEPTH.
  - No overflow is possible; the credit rule guarantees space for every in-flight word.
- FIFO empty: no read is issued. An inflight word captured while the FIFO goes empty is still delivered.
- Reset mid-operation: a buffered word and an in-flight word are both discarded and not counted.
  - The upstream FIFO is reset by the same system reset.
- Invariant: buf_count + inflight <= BUF_DEPTH at all times (assert).
- Illegal state: a capture with the buffer full is impossible. Flag it with an assertion only; no recovery logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, fifo_empty=1 -> fifo_rd_en=0, m_valid=0, buf_count=0, words_out=0 throughout.
- First-word latency: FIFO holds 0xA5A5, m_ready=1 -> fifo_rd_en=1 in cycle 0, m_valid=1 with m_data=0xA5A5 in cycle 2, words_out=1 after handshake.
- Streaming: write 10 words 0x0001..0x000A to the FIFO, m_ready=1 -> 10 consecutive m_valid cycles, data in order, words_out=10, no bubbles after the first word.
- Backpressure: FIFO holds 8 words, m_ready=0 for 10 cycles -> exactly 3 rd_en pulses, buf_count=3, m_data held at the first word. Release m_ready -> remaining words delivered in order, total 8.
- Random m_ready (50%) over 200 cycles with random FIFO writes -> output sequence equals write sequence (scoreboard), invariant never violated.
- Reset mid-stream: assert rst with buf_count=2 and inflight=1 -> next cycle buf_count=0, m_valid=0, words_out=0. Words subsequently written to the freshly reset FIFO are delivered correctly.
